ifetch: RTL

Instruction fetch stage that drives the instruction memory and delivers `{pc, instr}` pairs to decode over a valid/ready handshake. It sits directly upstream of `imem`, supplying `re` and `addr`. It absorbs the one-cycle synchronous read latency of the BSRAM variant through a 2-entry buffer, so decode back-pressure never loses an instruction. Branch and jump redirects from execute restart fetch and discard stale words.

---
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch.sv | 94 +++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Fetch-side bundle: instruction memory port, redirect input and the
// valid/ready channel toward decode. The master modport is the fetch stage.
interface ifetch_if #(
   parameter int unsigned ADDR_W = 11
);
   logic              imem_re;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              if_valid;
   logic              if_ready;
   logic [31:0]       if_pc;
   logic [31:0]       if_instr;

   modport master (
      output imem_re, imem_addr, if_valid, if_pc, if_instr,
      input  imem_data, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_re, imem_addr, if_valid, if_pc, if_instr,
      output imem_data, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: issues one-cycle-latency imem reads under a 2-entry credit
// scheme and presents {pc, instr} to decode; redirects flush and restart fetch.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 11
) (
   input  logic     clk,
   input  logic     rst,
   ifetch_if.master bus
);

   logic [31:0] r_fetch_pc;
   logic [31:0] r_pend_pc;
   logic        r_pend;
   logic [1:0]  r_count;
   logic [31:0] r_pc    [2];
   logic [31:0] r_instr [2];

   logic        w_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_issue;
   logic [2:0]  w_credit;
   logic [31:0] w_redir_pc;
   logic [31:0] w_req_pc;

   assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
   assign w_valid    = (r_count != 2'd0) & ~bus.redirect_valid;
   assign w_pop      = w_valid & bus.if_ready;
   assign w_push     = r_pend & ~bus.redirect_valid;

   // Words already buffered or in flight, after this cycle's pop, bound new reads.
   assign w_credit = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop};
   assign w_issue  = bus.redirect_valid | (w_credit < 3'd2);
   assign w_req_pc = bus.redirect_valid ? w_redir_pc : r_fetch_pc;

   assign bus.imem_re   = w_issue & rst;
   assign bus.imem_addr = w_req_pc[ADDR_W+1:2];
   assign bus.if_valid  = w_valid;
   assign bus.if_pc     = r_pc[0];
   assign bus.if_instr  = r_instr[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_pend_pc  <= 32'd0;
         r_pend     <= 1'b0;
         r_count    <= 2'd0;
         r_pc[0]    <= 32'd0;
         r_pc[1]    <= 32'd0;
         r_instr[0] <= 32'd0;
         r_instr[1] <= 32'd0;
      end else begin
         if (w_issue) begin
            r_pend     <= 1'b1;
            r_pend_pc  <= w_req_pc;
            r_fetch_pc <= w_req_pc + 32'd4;
         end else begin
            r_pend <= 1'b0;
         end

         // Entry 0 is always the head; entry 1 shifts down on a pop.
         if (bus.redirect_valid) begin
            r_count <= 2'd0;
         end else begin
            case ({w_push, w_pop})
               2'b10: begin
                  r_pc[r_count[0]]    <= r_pend_pc;
                  r_instr[r_count[0]] <= bus.imem_data;
                  r_count             <= r_count + 2'd1;
               end
               2'b01: begin
                  r_pc[0]    <= r_pc[1];
                  r_instr[0] <= r_instr[1];
                  r_count    <= r_count - 2'd1;
               end
               2'b11: begin
                  if (r_count == 2'd1) begin
                     r_pc[0]    <= r_pend_pc;
                     r_instr[0] <= bus.imem_data;
                  end else begin
                     r_pc[0]    <= r_pc[1];
                     r_instr[0] <= r_instr[1];
                     r_pc[1]    <= r_pend_pc;
                     r_instr[1] <= bus.imem_data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
